// File: rtl/line_clear_compactor_if.sv
// Bundle between the line-clear engine, its requester (piece-lock executor)
// and the playfield matrix memory.
//   slave  : engine side (line_clear_compactor)
//   master : requester/memory side
// Requester: v_i, mode_i, clr_total_i -> engine; ready_o, done_o, clear_count_o,
//            top_out_o, lines_total_o <- engine.
// Memory:    mm_read_addr_o, mm_write_addr_o, mm_write_data_o, mm_write_v_o <- engine;
//            mm_read_data_i -> engine (combinational read).
interface line_clear_compactor_if #(
    parameter int unsigned width_p       = 16,
    parameter int unsigned height_p      = 32,
    parameter int unsigned total_width_p = 16
);
    localparam int unsigned AW = $clog2(height_p);
    localparam int unsigned CW = $clog2(height_p + 1);

    logic                     v_i;
    logic                     mode_i;
    logic                     ready_o;
    logic                     done_o;
    logic [CW-1:0]            clear_count_o;
    logic                     top_out_o;
    logic [total_width_p-1:0] lines_total_o;
    logic                     clr_total_i;
    logic [AW-1:0]            mm_read_addr_o;
    logic [width_p-1:0]       mm_read_data_i;
    logic [AW-1:0]            mm_write_addr_o;
    logic [width_p-1:0]       mm_write_data_o;
    logic                     mm_write_v_o;

    modport slave (
        input  v_i, mode_i, clr_total_i, mm_read_data_i,
        output ready_o, done_o, clear_count_o, top_out_o, lines_total_o,
        output mm_read_addr_o, mm_write_addr_o, mm_write_data_o, mm_write_v_o
    );

    modport master (
        output v_i, mode_i, clr_total_i, mm_read_data_i,
        input  ready_o, done_o, clear_count_o, top_out_o, lines_total_o,
        input  mm_read_addr_o, mm_write_addr_o, mm_write_data_o, mm_write_v_o
    );
endinterface

// File: rtl/line_clear_compactor.sv
// Single-pass line-clear engine. Scans the matrix bottom to top, drops full rows,
// compacts survivors downward and zero-fills the freed rows at the top.
// Ports:
//   clk_i      : clock, rising edge
//   reset_n_i  : asynchronous active-low reset
//   bus        : line_clear_compactor_if.slave (request/status + matrix memory port)
module line_clear_compactor #(
    parameter int unsigned width_p       = 16,
    parameter int unsigned height_p      = 32,
    parameter int unsigned total_width_p = 16,
    parameter int unsigned debug_p       = 0
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    line_clear_compactor_if.slave         bus
);
    localparam int unsigned AW = $clog2(height_p);
    localparam int unsigned CW = $clog2(height_p + 1);
    localparam int unsigned SW = total_width_p + 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StScan = 2'd1;
    localparam logic [1:0] StFill = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam logic [AW-1:0]            PtrBottom = AW'(height_p - 1);
    localparam logic [total_width_p-1:0] TotalMax  = '1;

    logic [1:0]               state_q, state_d;
    logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     mode_q, mode_d;
    logic                     top_q, top_d;
    logic [CW-1:0]            clear_count_q, clear_count_d;
    logic                     top_out_q, top_out_d;
    logic [total_width_p-1:0] total_q, total_d;

    logic          row_full;
    logic          row_empty;
    logic [CW-1:0] cnt_scan;
    logic [SW-1:0] total_sum;

    assign row_full  = &bus.mm_read_data_i;
    assign row_empty = ~|bus.mm_read_data_i;
    assign cnt_scan  = row_full ? cnt_q + CW'(1) : cnt_q;
    assign total_sum = {1'b0, total_q} + SW'(cnt_q);

    always_comb begin
        state_d       = state_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        cnt_d         = cnt_q;
        mode_d        = mode_q;
        top_d         = top_q;
        clear_count_d = clear_count_q;
        top_out_d     = top_out_q;
        total_d       = total_q;

        unique case (state_q)
            StIdle: begin
                if (bus.v_i) begin
                    rd_ptr_d = PtrBottom;
                    wr_ptr_d = PtrBottom;
                    cnt_d    = '0;
                    mode_d   = bus.mode_i;
                    state_d  = StScan;
                end
            end
            StScan: begin
                cnt_d    = cnt_scan;
                rd_ptr_d = rd_ptr_q - AW'(1);
                // Survivors claim the next slot; full rows leave wr_ptr behind.
                if (!row_full) begin
                    wr_ptr_d = wr_ptr_q - AW'(1);
                end
                if (rd_ptr_q == '0) begin
                    // Row 0 ends up non-empty only if nothing was cleared.
                    top_d   = !row_full && !row_empty && (cnt_scan == '0);
                    state_d = (cnt_scan != '0 && !mode_q) ? StFill : StDone;
                end
            end
            StFill: begin
                wr_ptr_d = wr_ptr_q - AW'(1);
                if (wr_ptr_q == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                clear_count_d = cnt_q;
                top_out_d     = top_q;
                total_d       = total_sum[SW-1] ? TotalMax : total_sum[total_width_p-1:0];
                state_d       = StIdle;
            end
        endcase

        // Clear wins over a same-cycle accumulation.
        if (bus.clr_total_i) begin
            total_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= StIdle;
            rd_ptr_q      <= PtrBottom;
            wr_ptr_q      <= PtrBottom;
            cnt_q         <= '0;
            mode_q        <= 1'b0;
            top_q         <= 1'b0;
            clear_count_q <= '0;
            top_out_q     <= 1'b0;
            total_q       <= '0;
        end else begin
            state_q       <= state_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            cnt_q         <= cnt_d;
            mode_q        <= mode_d;
            top_q         <= top_d;
            clear_count_q <= clear_count_d;
            top_out_q     <= top_out_d;
            total_q       <= total_d;
        end
    end

    assign bus.ready_o         = (state_q == StIdle);
    assign bus.done_o          = (state_q == StDone);
    assign bus.clear_count_o   = clear_count_q;
    assign bus.top_out_o       = top_out_q;
    assign bus.lines_total_o   = total_q;
    assign bus.mm_read_addr_o  = rd_ptr_q;
    assign bus.mm_write_addr_o = wr_ptr_q;
    assign bus.mm_write_data_o = (state_q == StScan) ? bus.mm_read_data_i : '0;
    // A survivor already in place (rd == wr) needs no write.
    assign bus.mm_write_v_o    = ((state_q == StScan) && !mode_q && !row_full &&
                                  (rd_ptr_q != wr_ptr_q)) || (state_q == StFill);
endmodule
